instr_issuer: RTL and testbench
===============================

Name: instr_issuer

Overview:
- Program sequencer that feeds the 9-bit simple processor's control unit from the other side of its Din/run/Done interface.
- Reads a synchronous instruction ROM and presents each instruction word on din_o, then pulses run_o. For mvi it also presents the immediate word.
- Waits for done_i before issuing the next instruction. It halts at the end of the program, on an illegal opcode, or on a Done timeout.
- Sits between the program ROM and the processor's Din/run/Done pins.

Parameters:
- ADDR_W, 5: ROM address width.
- PROG_LEN, 32: number of valid ROM words, 1..2^ADDR_W.
- TIMEOUT, 7: maximum EXEC cycles to wait for done_i before flagging an error.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle pulse; begins a program run at address 0.
- rom_addr  out  ADDR_W  ROM read address; data returns on rom_data one cycle later.
- rom_data  in  9  ROM read data.
- done_i  in  1  processor Done.
- din_o  out  9  processor Din.
- run_o  out  1  processor run.
- busy  out  1  high in any state other than IDLE or HALT.
- halted  out  1  high in HALT.
- err  out  1  sticky error flag; cleared by start or rst.
- pc_o  out  ADDR_W  address of the current instruction.

Behaviour:
- Reset (async, rst=1): state=IDLE; pc, ir_q, imm_q, timeout counter, rom_addr, din_o, pc_o = 0; run_o, busy, halted, err = 0. Reset mid-instruction drops run_o immediately.
- Opcode field ir[8:6]: 000 mv, 001 mvi, 010 add, 011 sub, 1xx illegal.
- Processor contract: IR loads Din on every fetch cycle, and the transition decision uses the previous IR. The instruction therefore needs one setup cycle with run=0 and then one run=1 cycle, Din held constant in both. The mvi immediate must be on Din in the cycle after the run=1 cycle. Done is high in the last execute cycle.

States (din_o shows ir_q unless stated):
- IDLE: run_o=0. On start: pc=0, err=0, go to RD_I.
- RD_I: rom_addr=pc. Go to LAT_I.
- LAT_I: ir_q<=rom_data.
  - If rom_data[8]=1: err=1, go to HALT; nothing is issued.
  - Else if mvi: if pc==PROG_LEN-1, err=1, go to HALT; otherwise rom_addr=pc+1, go to LAT_M.
  - Else go to SETUP.
- LAT_M: imm_q<=rom_data. Go to SETUP.
- SETUP: din_o=ir_q, run_o=0. Go to ISSUE.
- ISSUE: din_o=ir_q, run_o=1, for exactly one cycle. Go to EXEC; timeout counter=0.
- EXEC: run_o=0; din_o=imm_q if mvi, else ir_q. Counter increments each cycle.
  - done_i=1: pc<=pc+1 (pc+2 for mvi). If the new pc>=PROG_LEN go to HALT, else RD_I.
  - Counter reaches TIMEOUT with done_i=0: err=1, go to HALT.
- HALT: halted=1, run_o=0, din_o holds its last value. On start: restart as from IDLE.

Rules:
- Expected done_i arrives in the 1st EXEC cycle for mv/mvi and the 3rd for add/sub.
- done_i outside EXEC is ignored.
- start is ignored while busy.
- pc arithmetic is ADDR_W+1 bits wide so the end test cannot wrap.
- pc_o=pc.
- Minimum issue period per instruction: RD_I, LAT_I, [LAT_M], SETUP, ISSUE, then the EXEC cycles.

Test Plan:
- ROM {0:000_001_010 (mv R1,R2)}, PROG_LEN=1, start. Required: SETUP din_o=0x00A run_o=0; ISSUE run_o=1; done_i in EXEC cycle 1; then HALT with halted=1, err=0, exactly one run_o pulse.
- ROM {0:001_011_000 (mvi R3), 1:0x155}, PROG_LEN=2. Required: EXEC cycle din_o=0x155; after done_i, pc=2 and HALT, err=0.
- ROM {add R0,R1; sub R2,R3}, model responds with Done in EXEC cycle 3. Required: two run_o pulses; each EXEC lasts 3 cycles with din_o=ir_q; pc_o reads 0 then 1; final halted=1.
- ROM word 0=0x1C0 (illegal opcode). Required: run_o never asserts; HALT with err=1. A following start clears err and re-reads address 0.
- mvi at address PROG_LEN-1. Required: err=1, no run_o pulse. Separately, done_i held 0 in EXEC: err=1 after TIMEOUT=7 cycles, run_o=0.
- Assert rst during the EXEC of an add. Required: run_o, busy, err, din_o=0 immediately. A start pulse while busy has no effect.

Source files
------------

// File: rtl/instr_issuer.sv
// Program sequencer feeding a 9-bit processor's Din/run/Done interface
// from a synchronous instruction ROM.
module instr_issuer #(
    parameter int ADDR_W   = 5,
    parameter int PROG_LEN = 32,
    parameter int TIMEOUT  = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [8:0]        rom_data,
    input  logic              done_i,
    output logic [8:0]        din_o,
    output logic              run_o,
    output logic              busy,
    output logic              halted,
    output logic              err,
    output logic [ADDR_W-1:0] pc_o
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W:0] LEN  = (ADDR_W + 1)'(PROG_LEN);
    localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(PROG_LEN - 1);
    localparam logic [2:0] OP_MVI = 3'b001;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_I,
        S_LAT_I,
        S_LAT_M,
        S_SETUP,
        S_ISSUE,
        S_EXEC,
        S_HALT
    } state_t;

    state_t            r_state;
    logic [ADDR_W:0]   r_pc;
    logic [8:0]        r_ir;
    logic [8:0]        r_imm;
    logic [CW-1:0]     r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [8:0]        r_din;
    logic              r_run;
    logic              r_busy;
    logic              r_halted;
    logic              r_err;

    logic              w_ir_mvi;
    logic              w_rd_mvi;
    logic [ADDR_W:0]   w_pc_step;
    logic [CW-1:0]     w_cnt_nx;

    assign w_ir_mvi  = (r_ir[8:6] == OP_MVI);
    assign w_rd_mvi  = (rom_data[8:6] == OP_MVI);
    assign w_pc_step = r_pc + (w_ir_mvi ? (ADDR_W + 1)'(2) : (ADDR_W + 1)'(1));
    assign w_cnt_nx  = r_cnt + CW'(1);

    assign rom_addr = r_addr;
    assign din_o    = r_din;
    assign run_o    = r_run;
    assign busy     = r_busy;
    assign halted   = r_halted;
    assign err      = r_err;
    assign pc_o     = r_pc[ADDR_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_pc     <= '0;
            r_ir     <= '0;
            r_imm    <= '0;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_din    <= '0;
            r_run    <= 1'b0;
            r_busy   <= 1'b0;
            r_halted <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        r_pc     <= '0;
                        r_addr   <= '0;
                        r_err    <= 1'b0;
                        r_busy   <= 1'b1;
                        r_halted <= 1'b0;
                        r_state  <= S_RD_I;
                    end
                end
                S_RD_I: begin
                    // Prefetch the next word so an mvi immediate lands in LAT_M.
                    r_addr  <= r_pc[ADDR_W-1:0] + ADDR_W'(1);
                    r_state <= S_LAT_I;
                end
                S_LAT_I: begin
                    r_ir <= rom_data;
                    if (rom_data[8] || (w_rd_mvi && r_pc == LAST)) begin
                        r_err    <= 1'b1;
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
                        r_state  <= S_HALT;
                    end else if (w_rd_mvi) begin
                        r_state <= S_LAT_M;
                    end else begin
                        r_din   <= rom_data;
                        r_state <= S_SETUP;
                    end
                end
                S_LAT_M: begin
                    r_imm   <= rom_data;
                    r_din   <= r_ir;
                    r_state <= S_SETUP;
                end
                S_SETUP: begin
                    r_run   <= 1'b1;
                    r_state <= S_ISSUE;
                end
                S_ISSUE: begin
                    r_run   <= 1'b0;
                    r_cnt   <= '0;
                    if (w_ir_mvi) begin
                        r_din <= r_imm;
                    end
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_cnt <= w_cnt_nx;
                    if (done_i) begin
                        r_pc <= w_pc_step;
                        if (w_pc_step >= LEN) begin
                            r_busy   <= 1'b0;
                            r_halted <= 1'b1;
                            r_state  <= S_HALT;
                        end else begin
                            r_addr  <= w_pc_step[ADDR_W-1:0];
                            r_state <= S_RD_I;
                        end
                    end else if (w_cnt_nx == CW'(TIMEOUT)) begin
                        r_err    <= 1'b1;
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
                        r_state  <= S_HALT;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_issuer.sv
// Testbench for instr_issuer: ROM + processor responder with a
// program-walking reference model.
module tb_instr_issuer;

    localparam int AW  = 5;
    localparam int LEN = 6;
    localparam int TO  = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] rom_addr;
    logic [8:0]    rom_data = '0;
    logic          done_i;
    logic [8:0]    din_o;
    logic          run_o;
    logic          busy;
    logic          halted;
    logic          err;
    logic [AW-1:0] pc_o;

    logic [8:0] rom [32];

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] exp_ir[$];
    logic [8:0] exp_ex[$];
    int         exp_pc[$];
    bit         exp_err;
    bit         exp_to;

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    instr_issuer #(
        .ADDR_W  (AW),
        .PROG_LEN(LEN),
        .TIMEOUT (TO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .done_i  (done_i),
        .din_o   (din_o),
        .run_o   (run_o),
        .busy    (busy),
        .halted  (halted),
        .err     (err),
        .pc_o    (pc_o)
    );

    // Walk the program as the processor would see it issued.
    task automatic model(input int to_idx);
        int pc;
        int n;
        logic [8:0] w;
        bit mvi;
        exp_ir.delete();
        exp_ex.delete();
        exp_pc.delete();
        exp_err = 0;
        exp_to  = 0;
        pc = 0;
        n  = 0;
        while (pc < LEN) begin
            w = rom[pc];
            if (w[8]) begin
                exp_err = 1;
                break;
            end
            mvi = (w[8:6] == 3'b001);
            if (mvi && pc == LEN - 1) begin
                exp_err = 1;
                break;
            end
            exp_ir.push_back(w);
            exp_ex.push_back(mvi ? rom[pc+1] : w);
            exp_pc.push_back(pc);
            if (n == to_idx) begin
                exp_err = 1;
                exp_to  = 1;
                break;
            end
            n++;
            pc += mvi ? 2 : 1;
        end
    endtask

    task automatic fill_random();
        for (int a = 0; a < 32; a++) rom[a] = 9'($urandom);
    endtask

    task automatic gen_prog(input bit allow_ill);
        int a;
        logic [2:0] op;
        fill_random();
        a = 0;
        while (a < LEN) begin
            op = 3'($urandom_range(0, 3));
            if (op == 3'b001 && a == LEN - 1) op = 3'b000;
            rom[a] = {op, 6'($urandom)};
            a += (op == 3'b001) ? 2 : 1;
        end
        if (allow_ill) rom[$urandom_range(0, LEN - 1)] = {3'b1, 6'($urandom)} | 9'h100;
    endtask

    task automatic run_prog(input string tag, input int to_idx);
        int np = 0;
        int ek = 0;
        int want = 0;
        int cur = 0;
        bit seen_halt = 0;
        logic [8:0] prev_din;
        logic prev_run;
        logic [8:0] w;
        model(to_idx);
        @(negedge clk);
        start  = 1'b1;
        done_i = 1'b0;
        prev_din = din_o;
        prev_run = run_o;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == 0) begin
                n_checks++;
                if ({busy, halted, err} !== 3'b100 || rom_addr !== '0) begin
                    n_fail++;
                    $display("FAIL %s start: busy/halted/err=%b addr=%0d want 100 addr 0",
                             tag, {busy, halted, err}, rom_addr);
                end
            end
            if (halted) begin
                seen_halt = 1;
                break;
            end
            if (run_o) begin
                if (np < exp_ir.size()) begin
                    w = exp_ir[np];
                    n_checks++;
                    if (din_o !== w || prev_din !== w || prev_run !== 1'b0
                        || pc_o !== AW'(exp_pc[np])) begin
                        n_fail++;
                        $display("FAIL %s issue%0d: din=%h setup_din=%h prev_run=%b pc=%0d want din %h pc %0d",
                                 tag, np, din_o, prev_din, prev_run, pc_o, w, exp_pc[np]);
                    end
                    want = (np == to_idx) ? 0 : (w[7] ? 3 : 1);
                end else begin
                    want = 1;
                end
                cur = np;
                np++;
                ek = 1;
                done_i = 1'($urandom_range(0, 1));
            end else if (ek > 0) begin
                if (ek == 1 && cur < exp_ex.size()) begin
                    n_checks++;
                    if (din_o !== exp_ex[cur]) begin
                        n_fail++;
                        $display("FAIL %s exec_din%0d: got %h want %h", tag, cur, din_o, exp_ex[cur]);
                    end
                end
                done_i = (ek == want);
                ek = (ek == want) ? 0 : ek + 1;
            end else begin
                done_i = 1'($urandom_range(0, 1));
            end
            if (busy && $urandom_range(0, 7) == 0) start = 1'b1;
            prev_din = din_o;
            prev_run = run_o;
        end
        start  = 1'b0;
        done_i = 1'b0;
        n_checks++;
        if (!seen_halt) begin
            n_fail++;
            $display("FAIL %s budget: no halt within 400 cycles", tag);
        end
        n_checks++;
        if (np != exp_ir.size() || err !== exp_err || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s end: pulses=%0d err=%b busy=%b want pulses %0d err %b busy 0",
                     tag, np, err, busy, exp_ir.size(), exp_err);
        end
        if (exp_to) begin
            n_checks++;
            if (ek - 1 != TO) begin
                n_fail++;
                $display("FAIL %s timeout: exec cycles %0d want %0d", tag, ek - 1, TO);
            end
        end
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        start  = 1'b0;
        done_i = 1'b0;
        fill_random();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({run_o, busy, halted, err} !== 4'b0 || din_o !== '0
            || rom_addr !== '0 || pc_o !== '0) begin
            n_fail++;
            $display("FAIL reset: run/busy/halt/err=%b din=%h addr=%0d pc=%0d want all 0",
                     {run_o, busy, halted, err}, din_o, rom_addr, pc_o);
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            done_i = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        done_i = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || run_o !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_done: busy=%b run=%b want 0 0", busy, run_o);
        end
    endtask

    task automatic test_mv();
        fill_random();
        for (int a = 0; a < LEN; a++) rom[a] = 9'h00A;
        run_prog("mv", -1);
    endtask

    task automatic test_mvi();
        fill_random();
        rom[0] = 9'h058; rom[1] = 9'h155;
        rom[2] = 9'h048; rom[3] = 9'h0AA;
        rom[4] = 9'h040; rom[5] = 9'h1FF;
        run_prog("mvi", -1);
    endtask

    task automatic test_addsub();
        fill_random();
        for (int a = 0; a < LEN; a++) rom[a] = (a % 2 == 0) ? 9'h081 : 9'h0D3;
        run_prog("addsub", -1);
    endtask

    task automatic test_illegal();
        fill_random();
        rom[0] = 9'h1C0;
        run_prog("illegal", -1);
        for (int a = 0; a < LEN; a++) rom[a] = 9'h011;
        run_prog("restart", -1);
    endtask

    task automatic test_mvi_last();
        fill_random();
        for (int a = 0; a < LEN - 1; a++) rom[a] = 9'h00A;
        rom[LEN-1] = 9'h040;
        run_prog("mvi_last", -1);
    endtask

    task automatic test_timeout();
        for (int k = 0; k < 3; k++) begin
            gen_prog(0);
            run_prog("timeout", k);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 20; k++) begin
            gen_prog($urandom_range(0, 3) == 0);
            run_prog("random", ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 2)) : -1);
        end
    endtask

    task automatic wait_run(input string tag);
        bit got = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (run_o) begin
                got = 1;
                break;
            end
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL %s wait_run: run_o never rose", tag);
        end
    endtask

    task automatic test_rst_mid();
        fill_random();
        for (int a = 0; a < LEN; a++) rom[a] = (a % 2 == 0) ? 9'h081 : 9'h0D3;
        done_i = 1'b0;
        @(negedge clk);
        start = 1'b1;
        wait_run("rst_issue");
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (run_o !== 1'b0 || busy !== 1'b0 || din_o !== '0) begin
            n_fail++;
            $display("FAIL rst_issue: run=%b busy=%b din=%h want 0 0 0", run_o, busy, din_o);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start = 1'b1;
        wait_run("rst_exec");
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || din_o !== 9'h081) begin
            n_fail++;
            $display("FAIL exec_hold: busy=%b din=%h want 1 081", busy, din_o);
        end
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({run_o, busy, err, halted} !== 4'b0 || din_o !== '0) begin
            n_fail++;
            $display("FAIL rst_exec: run/busy/err/halt=%b din=%h want 0 0",
                     {run_o, busy, err, halted}, din_o);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mv();
        test_mvi();
        test_addsub();
        test_illegal();
        test_mvi_last();
        test_timeout();
        test_rst_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
